comp_refill_ctrl: RTL and testbench

COMP_REFILL_CTRL -- requirements
Module: comp_refill_ctrl

---
 rtl/comp_pkg.sv | 45 ++++
 rtl/refill_line_buf.sv | 60 ++++++
 rtl/comp_refill_ctrl.sv | 173 +++++++++++++++++
 tb/tb_comp_refill_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared refill types: FSM state encoding and the 7/10/15-bit instruction
// field split that feeds the 3/5/8-bit dictionary key lookups.
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } refill_state_e;

    localparam int unsigned VAL0_W  = 7;
    localparam int unsigned VAL1_W  = 10;
    localparam int unsigned VAL2_W  = 15;
    localparam int unsigned KEY0_W  = 3;
    localparam int unsigned KEY1_W  = 5;
    localparam int unsigned KEY2_W  = 8;
    localparam int unsigned INSTR_W = VAL0_W + VAL1_W + VAL2_W;
    localparam int unsigned COMP_W  = KEY0_W + KEY1_W + KEY2_W;

    typedef struct packed {
        logic [VAL0_W-1:0] f0;
        logic [VAL1_W-1:0] f1;
        logic [VAL2_W-1:0] f2;
    } instr_fields_t;

    typedef struct packed {
        logic [KEY0_W-1:0] k0;
        logic [KEY1_W-1:0] k1;
        logic [KEY2_W-1:0] k2;
    } comp_key_t;

    // f0 takes the top 7 bits, f1 the middle 10, f2 the low 15.
    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.f0 = instr[INSTR_W-1 -: VAL0_W];
        f.f1 = instr[VAL2_W +: VAL1_W];
        f.f2 = instr[0 +: VAL2_W];
        return f;
    endfunction

    function automatic logic [INSTR_W-1:0] merge_instr(input instr_fields_t f);
        return {f.f0, f.f1, f.f2};
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Line assembly registers: raw words and dictionary keys written slice by
// slice, plus the running AND of per-word dictionary hits.
module refill_line_buf #(
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned KEY_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(NUM_BLOCKS)-1:0] wr_idx_i,
    input  logic [31:0]                   raw_word_i,
    input  logic [KEY_W-1:0]              comp_key_i,
    input  logic                          hit_i,
    output logic [32*NUM_BLOCKS-1:0]      line_raw_o,
    output logic [KEY_W*NUM_BLOCKS-1:0]  line_comp_o,
    output logic                          all_hit_o
);

    localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);

    logic [32*NUM_BLOCKS-1:0]     raw_q, raw_d;
    logic [KEY_W*NUM_BLOCKS-1:0] comp_q, comp_d;
    logic                         all_hit_q, all_hit_d;

    always_comb begin
        raw_d     = raw_q;
        comp_d    = comp_q;
        all_hit_d = all_hit_q;
        if (clear_i) begin
            all_hit_d = 1'b1;
        end
        if (wr_en_i) begin
            for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
                if (wr_idx_i == IDX_W'(k)) begin
                    raw_d[k*32 +: 32]       = raw_word_i;
                    comp_d[k*KEY_W +: KEY_W] = comp_key_i;
                end
            end
            all_hit_d = all_hit_q & hit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q     <= '0;
            comp_q    <= '0;
            all_hit_q <= 1'b1;
        end else begin
            raw_q     <= raw_d;
            comp_q    <= comp_d;
            all_hit_q <= all_hit_d;
        end
    end

    assign line_raw_o  = raw_q;
    assign line_comp_o = comp_q;
    assign all_hit_o   = all_hit_q;

endmodule

// File: rtl/comp_refill_ctrl.sv
// Refill controller: fetches a line word by word, probes the dictionary per
// word, and hands the line to the compressed or raw icache.
// Define REFILL_STATS_EN to add saturating per-cache fill counters.
module comp_refill_ctrl
    import comp_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned KEY_W      = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         miss_valid,
    input  logic [31:0]                  miss_addr,
    output logic                         miss_ready,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [31:0]                  mem_req_addr,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  mem_resp_rdata,
    output logic [31:0]                  dict_word,
    input  logic                         dict_hit,
    input  logic [KEY_W-1:0]             dict_key,
    output logic                         fill_valid_raw,
    output logic                         fill_valid_comp,
    input  logic                         fill_ready,
    output logic [31:0]                  fill_addr,
`ifdef REFILL_STATS_EN
    output logic [31:0]                  stat_lines_raw,
    output logic [31:0]                  stat_lines_comp,
`endif
    output logic [32*NUM_BLOCKS-1:0]     fill_line_raw,
    output logic [KEY_W*NUM_BLOCKS-1:0] fill_line_comp
);

    localparam int unsigned      IDX_W    = $clog2(NUM_BLOCKS);
    localparam int unsigned      CNT_W    = IDX_W + 1;
    localparam int unsigned      OFF_W    = IDX_W + 2;
    localparam logic [31:0]      OFF_MASK = (32'd1 << OFF_W) - 32'd1;
    localparam logic [CNT_W-1:0] NB_C     = CNT_W'(NUM_BLOCKS);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(NUM_BLOCKS - 1);

    refill_state_e     state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  resp_cnt_q, resp_cnt_d;
    logic              line_clear;
    logic              resp_take;
    logic              line_comp;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        req_cnt_d       = req_cnt_q;
        resp_cnt_d      = resp_cnt_q;
        line_clear      = 1'b0;
        resp_take       = 1'b0;
        miss_ready      = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        dict_word       = '0;
        fill_valid_raw  = 1'b0;
        fill_valid_comp = 1'b0;
        fill_addr       = '0;

        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    base_d     = miss_addr & ~OFF_MASK;
                    req_cnt_d  = '0;
                    resp_cnt_d = '0;
                    line_clear = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (req_cnt_q < NB_C) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = base_q + (32'(req_cnt_q) << 2);
                    if (mem_req_ready) begin
                        req_cnt_d = req_cnt_q + 1'b1;
                    end
                end
                // Issue and capture are independent so requests stay pipelined.
                if (mem_resp_valid) begin
                    dict_word = mem_resp_rdata;
                    if (resp_cnt_q < NB_C) begin
                        resp_take  = 1'b1;
                        resp_cnt_d = resp_cnt_q + 1'b1;
                        if (resp_cnt_q == LAST_C) begin
                            state_d = ST_DELIVER;
                        end
                    end
                end
            end
            ST_DELIVER: begin
                fill_addr       = base_q;
                fill_valid_comp = line_comp;
                fill_valid_raw  = ~line_comp;
                if (fill_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    refill_line_buf #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .KEY_W      (KEY_W)
    ) u_line_buf (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .clear_i     (line_clear),
        .wr_en_i     (resp_take),
        .wr_idx_i    (resp_cnt_q[IDX_W-1:0]),
        .raw_word_i  (mem_resp_rdata),
        .comp_key_i  (dict_key),
        .hit_i       (dict_hit),
        .line_raw_o  (fill_line_raw),
        .line_comp_o (fill_line_comp),
        .all_hit_o   (line_comp)
    );

`ifdef REFILL_STATS_EN
    logic [31:0] stat_raw_q, stat_raw_d;
    logic [31:0] stat_comp_q, stat_comp_d;
    logic        fill_fire;

    assign fill_fire = (state_q == ST_DELIVER) && fill_ready;

    always_comb begin
        stat_raw_d  = stat_raw_q;
        stat_comp_d = stat_comp_q;
        if (fill_fire && !line_comp && (stat_raw_q != '1)) begin
            stat_raw_d = stat_raw_q + 32'd1;
        end
        if (fill_fire && line_comp && (stat_comp_q != '1)) begin
            stat_comp_d = stat_comp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_raw_q  <= '0;
            stat_comp_q <= '0;
        end else begin
            stat_raw_q  <= stat_raw_d;
            stat_comp_q <= stat_comp_d;
        end
    end

    assign stat_lines_raw  = stat_raw_q;
    assign stat_lines_comp = stat_comp_q;
`endif

endmodule

// File: tb/tb_comp_refill_ctrl.sv
// Randomized self-checking bench for comp_refill_ctrl against a line-level
// reference model (memory/dictionary responders plus expected-line builder).
`timescale 1ns/1ps
module tb_comp_refill_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned KW = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               miss_valid;
    logic [31:0]        miss_addr;
    logic               miss_ready;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [31:0]        mem_req_addr;
    logic               mem_resp_valid;
    logic [31:0]        mem_resp_rdata;
    logic [31:0]        dict_word;
    logic               dict_hit;
    logic [KW-1:0]      dict_key;
    logic               fill_valid_raw;
    logic               fill_valid_comp;
    logic               fill_ready;
    logic [31:0]        fill_addr;
    logic [32*NB-1:0]   fill_line_raw;
    logic [KW*NB-1:0]   fill_line_comp;
`ifdef REFILL_STATS_EN
    logic [31:0]        stat_lines_raw;
    logic [31:0]        stat_lines_comp;
`endif

    always #5 clk = ~clk;

    comp_refill_ctrl #(
        .NUM_BLOCKS (NB),
        .KEY_W      (KW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .miss_valid      (miss_valid),
        .miss_addr       (miss_addr),
        .miss_ready      (miss_ready),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .dict_word       (dict_word),
        .dict_hit        (dict_hit),
        .dict_key        (dict_key),
        .fill_valid_raw  (fill_valid_raw),
        .fill_valid_comp (fill_valid_comp),
        .fill_ready      (fill_ready),
        .fill_addr       (fill_addr),
`ifdef REFILL_STATS_EN
        .stat_lines_raw  (stat_lines_raw),
        .stat_lines_comp (stat_lines_comp),
`endif
        .fill_line_raw   (fill_line_raw),
        .fill_line_comp  (fill_line_comp)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: the current line's contents and dictionary verdicts
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    logic [31:0]  line_words [NB];
    logic         line_hits  [NB];
    pend_t        pend_q [$];
    logic [31:0]  req_log [$];
    int unsigned  cyc = 0;
    int unsigned  lat = 1;
    int unsigned  ready_mode = 0;
    int unsigned  resp_sent = 0;
    bit           track_dict = 1'b0;
    int unsigned  n_comp_fills = 0;
    int unsigned  n_raw_fills = 0;

    function automatic logic [KW-1:0] key_of(input logic [31:0] w);
        return w[15:0] ^ w[31:16] ^ 16'h5A5A;
    endfunction

    // Dictionary: a word hits iff the current line marks it as present
    always @(dict_word) begin
        dict_hit = 1'b0;
        dict_key = key_of(dict_word);
        for (int k = 0; k < NB; k++) begin
            if (line_words[k] == dict_word) dict_hit = line_hits[k];
        end
    end

    // Memory: in-order responses 'lat' cycles after each accepted request
    initial begin
        pend_t p;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (resetn && mem_req_valid && mem_req_ready) begin
                pend_q.push_back('{mem_req_addr, cyc + lat});
                req_log.push_back(mem_req_addr);
            end
            if (track_dict && mem_resp_valid) begin
                chk("dict_word", 256'(dict_word), 256'(mem_resp_rdata));
            end
            @(posedge clk);
            cyc++;
            #1;
            mem_resp_valid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                mem_resp_valid = 1'b1;
                mem_resp_rdata = line_words[int'((p.addr >> 2) % NB)];
                resp_sent++;
            end
            case (ready_mode)
                0:       mem_req_ready = 1'b1;
                1:       mem_req_ready = ~mem_req_ready;
                default: mem_req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic make_line(input logic [NB-1:0] hit_mask);
        for (int k = 0; k < NB; k++) begin
            line_words[k] = ($urandom & 32'hFFFF_FF00) | 32'h80 | 32'(k);
            line_hits[k]  = hit_mask[k];
        end
    endtask

    task automatic run_line(input logic [31:0] addr, input logic [NB-1:0] hit_mask,
                            input int unsigned lat_i, input int unsigned rmode,
                            input int unsigned hold_cycles, input bit hold_miss,
                            input bit chk_lat, input string tag);
        logic [31:0]      exp_base;
        logic [32*NB-1:0] exp_raw;
        logic [KW*NB-1:0] exp_comp;
        bit               exp_is_comp;
        int unsigned      cnt;
        bit               seen;

        make_line(hit_mask);
        exp_base    = addr - (addr % (NB * 4));
        exp_is_comp = 1'b1;
        for (int k = 0; k < NB; k++) begin
            exp_raw[k*32 +: 32]  = line_words[k];
            exp_comp[k*KW +: KW] = key_of(line_words[k]);
            if (!line_hits[k]) exp_is_comp = 1'b0;
        end
        lat        = lat_i;
        ready_mode = rmode;
        req_log.delete();
        track_dict = 1'b1;

        @(posedge clk); #2;
        chk({tag, " idle_ready"}, 256'(miss_ready), 256'(1));
        miss_valid = 1'b1;
        miss_addr  = addr;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(posedge clk); cnt++; #2;
            if (!hold_miss) miss_valid = 1'b0;
            if (fill_valid_raw || fill_valid_comp) seen = 1'b1;
        end
        miss_valid = 1'b0;
        chk({tag, " fill_seen"}, 256'(seen), 256'(1));
        if (chk_lat) chk({tag, " latency"}, 256'(cnt), 256'(NB + 2));
        if (seen) begin
            chk({tag, " valid_comp"}, 256'(fill_valid_comp), 256'(exp_is_comp));
            chk({tag, " valid_raw"}, 256'(fill_valid_raw), 256'(!exp_is_comp));
            chk({tag, " fill_addr"}, 256'(fill_addr), 256'(exp_base));
            chk({tag, " line_raw"}, 256'(fill_line_raw), 256'(exp_raw));
            chk({tag, " line_comp"}, 256'(fill_line_comp), 256'(exp_comp));
            chk({tag, " req_count"}, 256'(req_log.size()), 256'(NB));
            for (int k = 0; k < NB && k < req_log.size(); k++) begin
                chk({tag, " req_addr"}, 256'(req_log[k]), 256'(exp_base + 32'(4 * k)));
            end
            for (int h = 0; h < int'(hold_cycles); h++) begin
                @(posedge clk); #2;
                chk({tag, " hold_ctl"},
                    256'({fill_valid_comp, fill_valid_raw, miss_ready, mem_req_valid, fill_addr}),
                    256'({exp_is_comp, !exp_is_comp, 1'b0, 1'b0, exp_base}));
                chk({tag, " hold_line"}, 256'(fill_line_raw), 256'(exp_raw));
            end
            fill_ready = 1'b1;
            @(posedge clk); #2;
            fill_ready = 1'b0;
            if (exp_is_comp) n_comp_fills++;
            else             n_raw_fills++;
            chk({tag, " back_idle"},
                256'({miss_ready, fill_valid_comp, fill_valid_raw}), 256'(3'b100));
        end
        track_dict = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        int unsigned start;
        int unsigned cnt;
        bit          any_fill;

        make_line('1);
        lat        = 3;
        ready_mode = 0;
        track_dict = 1'b0;
        @(posedge clk); #2;
        start      = resp_sent;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3018;
        @(posedge clk); #2;
        miss_valid = 1'b0;
        cnt = 0;
        while (resp_sent < start + 2 && cnt < 50) begin
            @(posedge clk); cnt++; #2;
        end
        chk("rst two_resps", 256'(resp_sent - start), 256'(2));
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rst ctl",
            256'({miss_ready, mem_req_valid, fill_valid_comp, fill_valid_raw}), 256'(4'b1000));
        chk("rst addrs", 256'({mem_req_addr, fill_addr}), 256'(0));
        chk("rst bufs", 256'({fill_line_raw, fill_line_comp}), 256'(0));
        @(negedge clk);
        resetn = 1'b1;
        any_fill = 1'b0;
        repeat (10) begin
            @(posedge clk); #2;
            if (fill_valid_comp || fill_valid_raw) any_fill = 1'b1;
        end
        chk("rst no_fill", 256'(any_fill), 256'(0));
        chk("rst strays_done", 256'(pend_q.size()), 256'(0));
        chk("rst idle", 256'({miss_ready, mem_req_valid}), 256'(2'b10));
        chk("rst bufs_after", 256'({fill_line_raw, fill_line_comp}), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NB-1:0] mask;
        resetn     = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        fill_ready = 1'b0;
        for (int k = 0; k < NB; k++) begin
            line_words[k] = '0;
            line_hits[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset ctl",
            256'({miss_ready, mem_req_valid, fill_valid_comp, fill_valid_raw}), 256'(4'b1000));
        chk("reset addrs", 256'({mem_req_addr, fill_addr}), 256'(0));
        chk("reset bufs", 256'({fill_line_raw, fill_line_comp}), 256'(0));
        @(negedge clk);
        resetn = 1'b1;

        run_line(32'h0000_0104, 4'b1111, 1, 0, 0, 1'b0, 1'b1, "all_hit");
        run_line(32'h0000_0104, 4'b1011, 1, 0, 0, 1'b0, 1'b1, "word2_miss");
        run_line(32'h0000_0A38, 4'b1111, 3, 1, 0, 1'b0, 1'b0, "ready_toggle");
        run_line(32'h2000_0044, 4'b1111, 1, 0, 5, 1'b1, 1'b0, "fill_stall");
        run_line(32'hFFFF_FFFC, 4'b0000, 2, 0, 1, 1'b0, 1'b0, "top_addr");
        reset_mid_fetch();

        for (int i = 0; i < 12; i++) begin
            mask = ($urandom_range(0, 1) == 1) ? '1 : NB'($urandom);
            run_line($urandom, mask, $urandom_range(1, 4), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, "random");
        end

`ifdef REFILL_STATS_EN
        chk("stat_comp", 256'(stat_lines_comp), 256'(n_comp_fills));
        chk("stat_raw", 256'(stat_lines_raw), 256'(n_raw_fills));
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
